muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_sign_fix.sv | 48 ++++
 rtl/muldiv_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and defaults for the RV32M multiply/divide unit.
// Divider support is controlled by the MULDIV_DIV_EN macro in the files that import this package.
package muldiv_pkg;

  localparam int DEF_DATA_WIDTH          = 32;
  localparam int DEF_REG_FILE_ADDR_WIDTH = 5;

  // Encodings are the RV32M funct3 values.
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Operand magnitudes for the unsigned core and sign restoration of its raw results.
// Quotient/remainder handling exists only when MULDIV_DIV_EN is defined.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  muldiv_op_e                i_op,
  input  logic [DATA_WIDTH-1:0]     i_a,
  input  logic [DATA_WIDTH-1:0]     i_b,
  input  logic [2*DATA_WIDTH-1:0]   i_prod,
`ifdef MULDIV_DIV_EN
  input  logic [DATA_WIDTH-1:0]     i_quo,
  input  logic [DATA_WIDTH-1:0]     i_rem,
`endif
  output logic [DATA_WIDTH-1:0]     o_mag_a,
  output logic [DATA_WIDTH-1:0]     o_mag_b,
  output logic [DATA_WIDTH-1:0]     o_result
);

  logic                    w_a_signed;
  logic                    w_b_signed;
  logic                    w_neg_a;
  logic                    w_neg_b;
  logic [2*DATA_WIDTH-1:0] w_prod_fix;

  always_comb begin
    // MUL keeps operands unsigned: the low product half does not depend on signedness.
    w_a_signed = (i_op == OP_MULH) || (i_op == OP_MULHSU) || (i_op == OP_DIV) || (i_op == OP_REM);
    w_b_signed = (i_op == OP_MULH) || (i_op == OP_DIV) || (i_op == OP_REM);
    w_neg_a    = w_a_signed & i_a[DATA_WIDTH-1];
    w_neg_b    = w_b_signed & i_b[DATA_WIDTH-1];
    o_mag_a    = w_neg_a ? -i_a : i_a;
    o_mag_b    = w_neg_b ? -i_b : i_b;
    w_prod_fix = (w_neg_a ^ w_neg_b) ? -i_prod : i_prod;
    case (i_op)
      OP_MUL:                       o_result = w_prod_fix[DATA_WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: o_result = w_prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
`ifdef MULDIV_DIV_EN
      OP_DIV, OP_DIVU:              o_result = (w_neg_a ^ w_neg_b) ? -i_quo : i_quo;
      default:                      o_result = w_neg_a ? -i_rem : i_rem;
`else
      default:                      o_result = '0;
`endif
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MULDIV_DIV_EN to build the divider; otherwise ops 4-7 complete immediately with result 0.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH          = DEF_DATA_WIDTH,
  parameter int REG_FILE_ADDR_WIDTH = DEF_REG_FILE_ADDR_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [2:0]                     op,
  input  logic [DATA_WIDTH-1:0]          rs1_data,
  input  logic [DATA_WIDTH-1:0]          rs2_data,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] rd_addr,
  output logic                           busy,
  output logic                           done,
  output logic [DATA_WIDTH-1:0]          result,
  output logic [REG_FILE_ADDR_WIDTH-1:0] wb_addr,
  output logic                           wb_we,
  output muldiv_state_e                  dbg_state
);

  localparam int              CW   = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0]   LAST = CW'(DATA_WIDTH);

  muldiv_state_e                  r_state, w_next;
  muldiv_op_e                     r_op, w_sf_op;
  logic [DATA_WIDTH-1:0]          r_a, r_b, w_sf_a, w_sf_b;
  logic [DATA_WIDTH-1:0]          w_mag_a, w_mag_b, w_fixed, w_fast_result, w_addend;
  logic [REG_FILE_ADDR_WIDTH-1:0] r_rd, r_wb_addr;
  logic [DATA_WIDTH-1:0]          r_result;
  logic [CW-1:0]                  r_cnt;
  logic [2*DATA_WIDTH-1:0]        r_acc, w_acc_next;
  logic [DATA_WIDTH:0]            w_sum;
  logic                           w_accept, w_finish, w_fast, w_take_fast;

  // Before acceptance the sign stage sees the live inputs so the accumulator loads magnitudes at E0.
  assign w_sf_op = (r_state == ST_IDLE) ? muldiv_op_e'(op) : r_op;
  assign w_sf_a  = (r_state == ST_IDLE) ? rs1_data : r_a;
  assign w_sf_b  = (r_state == ST_IDLE) ? rs2_data : r_b;

  muldiv_sign_fix #(.DATA_WIDTH(DATA_WIDTH)) u_sign_fix (
    .i_op     (w_sf_op),
    .i_a      (w_sf_a),
    .i_b      (w_sf_b),
    .i_prod   (r_acc),
`ifdef MULDIV_DIV_EN
    .i_quo    (r_acc[DATA_WIDTH-1:0]),
    .i_rem    (r_acc[2*DATA_WIDTH-1:DATA_WIDTH]),
`endif
    .o_mag_a  (w_mag_a),
    .o_mag_b  (w_mag_b),
    .o_result (w_fixed)
  );

`ifdef MULDIV_DIV_EN
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  logic                  w_div_zero, w_ovf;
  logic [2*DATA_WIDTH:0] w_shift;
  logic [DATA_WIDTH-1:0] w_diff;

  always_comb begin
    w_div_zero = r_op[2] && (r_b == '0);
    w_ovf      = ((r_op == OP_DIV) || (r_op == OP_REM)) && (r_a == MOST_NEG) && (&r_b);
    w_fast     = w_div_zero || w_ovf;
    // op[1] distinguishes REM/REMU from DIV/DIVU.
    if (w_div_zero) w_fast_result = r_op[1] ? r_a : '1;
    else            w_fast_result = r_op[1] ? '0 : r_a;
  end
`else
  assign w_fast        = r_op[2];
  assign w_fast_result = '0;
`endif

  assign w_take_fast = (r_cnt == '0) && w_fast;

  always_comb begin
    w_addend   = r_acc[0] ? w_mag_a : '0;
    w_sum      = {1'b0, r_acc[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, w_addend};
    w_acc_next = {w_sum, r_acc[DATA_WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    // Partial remainder stays below the divisor, so the shifted top half never needs more than W+1 bits.
    w_shift = {r_acc, 1'b0};
    w_diff  = w_shift[2*DATA_WIDTH-1:DATA_WIDTH] - w_mag_b;
    if (r_op[2]) begin
      if (w_shift[2*DATA_WIDTH:DATA_WIDTH] >= {1'b0, w_mag_b})
        w_acc_next = {w_diff, w_shift[DATA_WIDTH-1:1], 1'b1};
      else
        w_acc_next = w_shift[2*DATA_WIDTH-1:0];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      ST_IDLE: if (start) begin
        w_next   = ST_CALC;
        w_accept = 1'b1;
      end
      ST_CALC: if (w_take_fast || (r_cnt == LAST)) begin
        w_next   = ST_DONE;
        w_finish = 1'b1;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= OP_MUL;
      r_a       <= '0;
      r_b       <= '0;
      r_rd      <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_result  <= '0;
      r_wb_addr <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= muldiv_op_e'(op);
        r_a   <= rs1_data;
        r_b   <= rs2_data;
        r_rd  <= rd_addr;
        r_cnt <= '0;
`ifdef MULDIV_DIV_EN
        r_acc <= {{DATA_WIDTH{1'b0}}, (op[2] ? w_mag_a : w_mag_b)};
`else
        r_acc <= {{DATA_WIDTH{1'b0}}, w_mag_b};
`endif
      end else if ((r_state == ST_CALC) && !w_finish) begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= w_acc_next;
      end
      if (w_finish) begin
        r_result  <= w_take_fast ? w_fast_result : w_fixed;
        r_wb_addr <= r_rd;
      end
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign result    = r_result;
  assign wb_addr   = r_wb_addr;
  assign dbg_state = r_state;
`ifdef MULDIV_DIV_EN
  assign wb_we = done && (r_wb_addr != '0);
`else
  assign wb_we = done && (r_wb_addr != '0) && !r_op[2];
`endif

endmodule
